ppu_run_control: RTL and testbench

- Parametrised successor PPU run/reset/interrupt controller.
- Generates the PPU master clock `xin` with a programmable divider.
- Supports free-run and counted single-step execution, and auto-stalls `xin` on any enabled interrupt.
- Interrupts come from NUM_INT synchronised PPU status lines, each with per-source edge polarity and per-bit clear.
- Drives both PPU reset lines: level hold/release, or a timed reset pulse.
- Sits between the host register file and the PPU pins.

---
 rtl/ppu_run_control.sv | 231 +++++++++++++++++++++++
 tb/tb_ppu_run_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_run_control.sv
`default_nettype none
// ============================================================================
// Module   : ppu_run_control
// Purpose  : Run/reset/interrupt controller for the PPU. Generates the PPU
//            master clock xin with a programmable half-period divider.
//            Supports free-run and counted single-step execution. Stalls
//            xin low whenever an enabled interrupt flag is set. Drives both
//            PPU reset lines, either as a level or as a timed pulse.
// Ports    : clock, reset            - system clock, async active-high reset
//            xin_enabled_i           - free-run enable
//            step_start_i/count_i    - start a counted step of N xin rises
//            div_i                   - xin half-period in clocks, minus 1
//            xin_stalled_o           - xin held low and not running
//            step_active_o           - step in progress
//            xin_counter_o           - running count of xin rising edges
//            set/clr_ppu_reset_i     - level hold / release of PPU reset
//            reset_pulse_i/len_i     - timed reset pulse, low for len+1 clocks
//            reset_busy_o            - timed pulse in progress
//            int_sources_i           - asynchronous PPU status lines
//            int_rise/enabled/clear_i- per-bit polarity, enable, clear
//            int_triggered_o/any_o   - sticky flags and their OR
//            xin, ppu1/2_reset_n     - PPU pins
// Revision : 1.0 - initial release
// ============================================================================
module ppu_run_control #(
  parameter int NUM_INT = 8,
  parameter int CNT_W   = 32,
  parameter int DIV_W   = 4,
  parameter int RST_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               xin_enabled_i,
  input  logic               step_start_i,
  input  logic [CNT_W-1:0]   step_count_i,
  input  logic [DIV_W-1:0]   div_i,
  output logic               xin_stalled_o,
  output logic               step_active_o,
  output logic [CNT_W-1:0]   xin_counter_o,
  input  logic               set_ppu_reset_i,
  input  logic               clr_ppu_reset_i,
  input  logic               reset_pulse_i,
  input  logic [RST_W-1:0]   reset_len_i,
  output logic               reset_busy_o,
  input  logic [NUM_INT-1:0] int_sources_i,
  input  logic [NUM_INT-1:0] int_rise_i,
  input  logic [NUM_INT-1:0] int_enabled_i,
  input  logic [NUM_INT-1:0] int_clear_i,
  output logic [NUM_INT-1:0] int_triggered_o,
  output logic               int_any_triggered_o,
  output logic               xin,
  output logic               ppu1_reset_n,
  output logic               ppu2_reset_n
);

  // --------------------------------------------------------------------------
  // Interrupt capture: 2-flop synchroniser, history flop, sticky flags
  // --------------------------------------------------------------------------
  logic [NUM_INT-1:0] sync1;
  logic [NUM_INT-1:0] sync2;
  logic [NUM_INT-1:0] prev;
  logic [NUM_INT-1:0] edge_hit;

  assign edge_hit = (int_rise_i & sync2 & ~prev) | (~int_rise_i & ~sync2 & prev);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1           <= '0;
      sync2           <= '0;
      prev            <= '0;
      int_triggered_o <= '0;
    end else begin
      sync1 <= int_sources_i;
      sync2 <= sync1;
      prev  <= sync2;
      // A new edge outranks a clear arriving in the same cycle.
      int_triggered_o <= (int_triggered_o & ~int_clear_i) | (edge_hit & int_enabled_i);
    end
  end

  assign int_any_triggered_o = |int_triggered_o;

  // --------------------------------------------------------------------------
  // xin generation
  // --------------------------------------------------------------------------
  logic             run;
  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;
  logic             xin_rise;
  logic [CNT_W-1:0] step_cnt;

  assign run      = (xin_enabled_i | step_active_o) & ~int_any_triggered_o;
  // >= rather than == so that lowering div_i mid-phase cannot force a full
  // counter wrap before the next transition.
  assign div_tc   = (div_cnt >= div_i);
  assign xin_rise = ~xin & run & div_tc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xin           <= 1'b0;
      div_cnt       <= '0;
      xin_stalled_o <= 1'b1;
    end else begin
      xin_stalled_o <= ~xin & ~run;
      if (xin) begin
        // The high phase always completes, even if run has dropped.
        if (div_tc) begin
          xin     <= 1'b0;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else if (run) begin
        if (div_tc) begin
          xin     <= 1'b1;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        // Parked low: restart takes a full div_i+1 clocks to the first rise.
        div_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Edge counter and step counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xin_counter_o <= '0;
      step_cnt      <= '0;
      step_active_o <= 1'b0;
    end else begin
      if (xin_rise) begin
        xin_counter_o <= xin_counter_o + CNT_W'(1);
      end
      if (step_start_i && (step_count_i != '0)) begin
        step_cnt      <= step_count_i;
        step_active_o <= 1'b1;
      end else if (xin_rise && step_active_o) begin
        step_cnt <= step_cnt - CNT_W'(1);
        if (step_cnt == CNT_W'(1)) begin
          step_active_o <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // PPU reset FSM
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_HELD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             pulse_load;
  logic [RST_W-1:0] pulse_cnt;
  logic             reset_n_next;
  logic             busy_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_HELD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pulse_load = 1'b0;
    case (state)
      ST_HELD: begin
        if (reset_pulse_i) begin
          state_next = ST_PULSE;
          pulse_load = 1'b1;
        end else if (clr_ppu_reset_i && !set_ppu_reset_i) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reset_pulse_i) begin
          state_next = ST_PULSE;
          pulse_load = 1'b1;
        end else if (set_ppu_reset_i && !clr_ppu_reset_i) begin
          state_next = ST_HELD;
        end
      end
      ST_PULSE: begin
        if (reset_pulse_i) begin
          pulse_load = 1'b1;
        end else if (pulse_cnt == '0) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_HELD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_comb begin
    reset_n_next = (state_next == ST_RUN);
    busy_next    = (state_next == ST_PULSE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_cnt    <= '0;
      ppu1_reset_n <= 1'b0;
      ppu2_reset_n <= 1'b0;
      reset_busy_o <= 1'b0;
    end else begin
      if (pulse_load) begin
        pulse_cnt <= reset_len_i;
      end else if ((state == ST_PULSE) && (pulse_cnt != '0)) begin
        pulse_cnt <= pulse_cnt - RST_W'(1);
      end
      ppu1_reset_n <= reset_n_next;
      ppu2_reset_n <= reset_n_next;
      reset_busy_o <= busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_run_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_run_control
// Purpose  : Directed self-checking bench for ppu_run_control. A second,
//            narrow-counter instance exercises edge-counter wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_run_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        xin_enabled_i = 1'b0;
  logic        step_start_i = 1'b0;
  logic [31:0] step_count_i = '0;
  logic [3:0]  div_i = '0;
  logic        xin_stalled_o;
  logic        step_active_o;
  logic [31:0] xin_counter_o;
  logic        set_ppu_reset_i = 1'b0;
  logic        clr_ppu_reset_i = 1'b0;
  logic        reset_pulse_i = 1'b0;
  logic [7:0]  reset_len_i = '0;
  logic        reset_busy_o;
  logic [7:0]  int_sources_i = '0;
  logic [7:0]  int_rise_i = '0;
  logic [7:0]  int_enabled_i = '0;
  logic [7:0]  int_clear_i = '0;
  logic [7:0]  int_triggered_o;
  logic        int_any_triggered_o;
  logic        xin;
  logic        ppu1_reset_n;
  logic        ppu2_reset_n;

  // narrow instance for wrap checking
  logic        en2 = 1'b0;
  logic        zero1 = 1'b0;
  logic [3:0]  zero4 = '0;
  logic [1:0]  zero2 = '0;
  logic [7:0]  zero8 = '0;
  logic        stalled2, active2, busy2, any2, xin2, r1n2, r2n2;
  logic [3:0]  cnt2;
  logic [7:0]  trig2;

  int total = 0;
  int bad   = 0;
  logic [31:0] c0;

  always #5 clock = ~clock;

  ppu_run_control dut (
    .clock(clock), .reset(reset),
    .xin_enabled_i(xin_enabled_i), .step_start_i(step_start_i),
    .step_count_i(step_count_i), .div_i(div_i),
    .xin_stalled_o(xin_stalled_o), .step_active_o(step_active_o),
    .xin_counter_o(xin_counter_o),
    .set_ppu_reset_i(set_ppu_reset_i), .clr_ppu_reset_i(clr_ppu_reset_i),
    .reset_pulse_i(reset_pulse_i), .reset_len_i(reset_len_i),
    .reset_busy_o(reset_busy_o),
    .int_sources_i(int_sources_i), .int_rise_i(int_rise_i),
    .int_enabled_i(int_enabled_i), .int_clear_i(int_clear_i),
    .int_triggered_o(int_triggered_o), .int_any_triggered_o(int_any_triggered_o),
    .xin(xin), .ppu1_reset_n(ppu1_reset_n), .ppu2_reset_n(ppu2_reset_n)
  );

  ppu_run_control #(.NUM_INT(8), .CNT_W(4), .DIV_W(2), .RST_W(8)) dut_wrap (
    .clock(clock), .reset(reset),
    .xin_enabled_i(en2), .step_start_i(zero1),
    .step_count_i(zero4), .div_i(zero2),
    .xin_stalled_o(stalled2), .step_active_o(active2),
    .xin_counter_o(cnt2),
    .set_ppu_reset_i(zero1), .clr_ppu_reset_i(zero1),
    .reset_pulse_i(zero1), .reset_len_i(zero8),
    .reset_busy_o(busy2),
    .int_sources_i(zero8), .int_rise_i(zero8),
    .int_enabled_i(zero8), .int_clear_i(zero8),
    .int_triggered_o(trig2), .int_any_triggered_o(any2),
    .xin(xin2), .ppu1_reset_n(r1n2), .ppu2_reset_n(r2n2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset values ----------------
    #12;
    chk("rst_xin",     64'(xin), 64'h0);
    chk("rst_stalled", 64'(xin_stalled_o), 64'h1);
    chk("rst_counter", 64'(xin_counter_o), 64'h0);
    chk("rst_step",    64'(step_active_o), 64'h0);
    chk("rst_trig",    64'(int_triggered_o), 64'h0);
    chk("rst_ppu1",    64'(ppu1_reset_n), 64'h0);
    chk("rst_ppu2",    64'(ppu2_reset_n), 64'h0);
    chk("rst_busy",    64'(reset_busy_o), 64'h0);

    // ---------------- free run, div=1 ----------------
    @(posedge clock); #1;
    reset = 1'b0;
    div_i = 4'd1;
    xin_enabled_i = 1'b1;
    tick(1);
    chk("run_first_low", 64'(xin), 64'h0);
    chk("run_not_stalled", 64'(xin_stalled_o), 64'h0);
    tick(1);
    chk("run_first_rise", 64'(xin), 64'h1);
    chk("run_cnt1", 64'(xin_counter_o), 64'h1);
    tick(16);
    chk("run_cnt5", 64'(xin_counter_o), 64'h5);
    tick(1);
    chk("run_high2", 64'(xin), 64'h1);
    tick(1);
    chk("run_fall", 64'(xin), 64'h0);

    // ---------------- rising-edge interrupt on bit 3 ----------------
    int_rise_i[3] = 1'b1;
    int_enabled_i[3] = 1'b1;
    int_sources_i[3] = 1'b1;
    tick(2);
    chk("int3_not_yet", 64'(int_triggered_o), 64'h0);
    chk("int3_rise_before", 64'(xin_counter_o), 64'h6);
    tick(1);
    chk("int3_set", 64'(int_triggered_o), 64'h08);
    chk("int3_any", 64'(int_any_triggered_o), 64'h1);
    tick(2);
    chk("int3_xin_low", 64'(xin), 64'h0);
    chk("int3_stalled", 64'(xin_stalled_o), 64'h1);
    tick(5);
    chk("int3_held", 64'(xin_counter_o), 64'h6);
    int_clear_i = 8'h08;
    tick(1);
    int_clear_i = 8'h00;
    chk("int3_cleared", 64'(int_triggered_o), 64'h0);
    tick(1);
    chk("resume_wait", 64'(xin), 64'h0);
    tick(1);
    chk("resume_rise", 64'(xin), 64'h1);
    chk("resume_cnt", 64'(xin_counter_o), 64'h7);

    // stop free run
    xin_enabled_i = 1'b0;
    tick(6);
    chk("stop_xin", 64'(xin), 64'h0);
    chk("stop_stalled", 64'(xin_stalled_o), 64'h1);
    chk("stop_cnt", 64'(xin_counter_o), 64'h7);

    // ---------------- falling-edge bit 0, disabled bit 5 ----------------
    int_rise_i[0] = 1'b0;
    int_enabled_i[0] = 1'b1;
    int_rise_i[5] = 1'b1;
    int_enabled_i[5] = 1'b0;
    int_sources_i[0] = 1'b1;
    int_sources_i[5] = 1'b1;
    tick(5);
    chk("fall_rise_ignored", 64'(int_triggered_o), 64'h00);
    int_sources_i[0] = 1'b0;
    tick(2);
    chk("fall_not_yet", 64'(int_triggered_o), 64'h00);
    tick(1);
    chk("fall_set", 64'(int_triggered_o), 64'h01);
    int_enabled_i[0] = 1'b0;
    tick(2);
    chk("fall_disable_keeps", 64'(int_triggered_o), 64'h01);
    int_enabled_i[0] = 1'b1;
    int_sources_i[0] = 1'b1;
    tick(5);
    int_sources_i[0] = 1'b0;
    tick(2);
    int_clear_i = 8'h01;
    tick(1);
    int_clear_i = 8'h00;
    chk("set_beats_clear", 64'(int_triggered_o), 64'h01);
    int_clear_i = 8'h01;
    tick(1);
    int_clear_i = 8'h00;
    chk("fall_cleared", 64'(int_triggered_o), 64'h00);

    // ---------------- counted step ----------------
    c0 = xin_counter_o;
    step_count_i = 32'd7;
    step_start_i = 1'b1;
    tick(1);
    step_start_i = 1'b0;
    chk("step_active", 64'(step_active_o), 64'h1);
    for (int i = 0; i < 200; i++) begin
      if (!step_active_o) break;
      tick(1);
    end
    chk("step_done", 64'(step_active_o), 64'h0);
    tick(6);
    chk("step_edges", 64'(xin_counter_o), 64'(c0 + 32'd7));
    chk("step_xin_low", 64'(xin), 64'h0);
    chk("step_stalled", 64'(xin_stalled_o), 64'h1);
    step_count_i = 32'd0;
    step_start_i = 1'b1;
    tick(1);
    step_start_i = 1'b0;
    chk("step0_inactive", 64'(step_active_o), 64'h0);
    tick(20);
    chk("step0_no_edges", 64'(xin_counter_o), 64'(c0 + 32'd7));

    // ---------------- PPU reset FSM ----------------
    set_ppu_reset_i = 1'b1;
    clr_ppu_reset_i = 1'b1;
    tick(1);
    set_ppu_reset_i = 1'b0;
    clr_ppu_reset_i = 1'b0;
    chk("held_setclr", 64'(ppu1_reset_n), 64'h0);
    clr_ppu_reset_i = 1'b1;
    tick(1);
    clr_ppu_reset_i = 1'b0;
    chk("release_ppu1", 64'(ppu1_reset_n), 64'h1);
    chk("release_ppu2", 64'(ppu2_reset_n), 64'h1);
    set_ppu_reset_i = 1'b1;
    clr_ppu_reset_i = 1'b1;
    tick(1);
    set_ppu_reset_i = 1'b0;
    clr_ppu_reset_i = 1'b0;
    chk("run_setclr", 64'(ppu1_reset_n), 64'h1);
    reset_len_i = 8'd9;
    reset_pulse_i = 1'b1;
    tick(1);
    reset_pulse_i = 1'b0;
    chk("pulse_low", 64'(ppu1_reset_n), 64'h0);
    chk("pulse_busy", 64'(reset_busy_o), 64'h1);
    tick(3);
    set_ppu_reset_i = 1'b1;
    tick(1);
    set_ppu_reset_i = 1'b0;
    tick(5);
    chk("pulse_last_low", 64'(ppu2_reset_n), 64'h0);
    chk("pulse_last_busy", 64'(reset_busy_o), 64'h1);
    tick(1);
    chk("pulse_end_ppu1", 64'(ppu1_reset_n), 64'h1);
    chk("pulse_end_ppu2", 64'(ppu2_reset_n), 64'h1);
    chk("pulse_end_busy", 64'(reset_busy_o), 64'h0);
    set_ppu_reset_i = 1'b1;
    tick(1);
    set_ppu_reset_i = 1'b0;
    chk("set_held", 64'(ppu1_reset_n), 64'h0);

    // ---------------- async reset mid-step and mid-pulse ----------------
    step_count_i = 32'd100;
    step_start_i = 1'b1;
    tick(1);
    step_start_i = 1'b0;
    tick(10);
    reset_len_i = 8'd50;
    reset_pulse_i = 1'b1;
    tick(1);
    reset_pulse_i = 1'b0;
    tick(2);
    chk("pre_rst_step", 64'(step_active_o), 64'h1);
    chk("pre_rst_busy", 64'(reset_busy_o), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_xin", 64'(xin), 64'h0);
    chk("arst_stalled", 64'(xin_stalled_o), 64'h1);
    chk("arst_counter", 64'(xin_counter_o), 64'h0);
    chk("arst_step", 64'(step_active_o), 64'h0);
    chk("arst_busy", 64'(reset_busy_o), 64'h0);
    chk("arst_ppu1", 64'(ppu1_reset_n), 64'h0);
    tick(2);
    reset = 1'b0;

    // ---------------- counter wrap on the narrow instance ----------------
    en2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cnt2 == 4'hF) break;
      tick(1);
    end
    chk("wrap_at_max", 64'(cnt2), 64'hF);
    tick(2);
    chk("wrap_to_zero", 64'(cnt2), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
